prga: RTL
=========

# prga

Pseudo-random generation stage of the ARC4 decryption datapath. Sits directly downstream of `ksa`. Once `ksa` has permuted the S memory, this block:
- regenerates the keystream from S,
- XORs it with the length-prefixed ciphertext memory,
- writes the length-prefixed plaintext memory.

It shares the same `en`/`rdy` handshake as `ksa`, so the top-level controller can sequence the init, ksa and prga stages identically.

## Interface
Parameters: none. Memory depth is fixed at 256 and data width at 8 bits.

Ports:
- `clk`  in  1  — single clock, all logic rising-edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `en`  in  1  — start request; sampled only while `rdy`=1.
- `rdy`  out  1  — 1 when idle and able to accept `en`.
- `s_addr`  out  8  — S memory address.
- `s_rddata`  in  8  — S read data.
- `s_wrdata`  out  8  — S write data.
- `s_wren`  out  1  — S write enable.
- `ct_addr`  out  8  — ciphertext memory address.
- `ct_rddata`  in  8  — ciphertext read data.
- `pt_addr`  out  8  — plaintext memory address.
- `pt_wrdata`  out  8  — plaintext write data.
- `pt_wren`  out  1  — plaintext write enable.

## Operation
- Memory format: byte 0 is the length L (0..255); bytes 1..L are the message.
- Algorithm, with i=j=0 at start, for k=1..L:
  - i=i+1
  - j=j+s[i]
  - swap s[i], s[j]
  - pt[k] = s[s[i]+s[j]] ^ ct[k]
- pt[0] = L.
- All index arithmetic is 8-bit, wrapping mod 256 (natural overflow, no saturation).
- All memories are synchronous-read: `rddata` is valid the cycle after the address is driven.
- FSM states:
  - IDLE: `rdy`=1. `en` → RD_LEN, with i, j, k cleared.
  - RD_LEN: `ct_addr`=0.
  - LD_LEN: latch L; write pt[0]=L. If L==0 → DONE, else → RD_I with k=1.
  - RD_I: `s_addr`=i+1; i←i+1.
  - LD_I: latch si; j←j+`s_rddata`.
  - RD_J: `s_addr`=j.
  - LD_J: latch sj.
  - WR_I: write s[i]=sj.
  - WR_J: write s[j]=si.
  - RD_K: `s_addr`=si+sj; `ct_addr`=k.
  - XOR: write pt[k]=`s_rddata`^`ct_rddata`. If k==L → DONE, else k←k+1 → RD_I.
  - DONE: one cycle, then → IDLE.
- Pad address uses the latched si and sj. Their sum is swap-invariant, so no re-read of S is needed.
- i==j: both swap writes hit the same address with the same value. This is legal; the result is that s[i] is unchanged.
- L=255: k must reach 255 without wrapping. The terminal compare is k==L, never k>L.
- `en` is ignored while `rdy`=0. `en` held high in IDLE restarts the block right after DONE.
- S contents are modified in place. A rerun needs S re-initialised upstream.

## Timing
- Reset values: `rdy`=1, all write enables 0, all addresses and write data 0, FSM=IDLE, i=j=k=0.
- Reset applies asynchronously, mid-operation included. Every write enable drops immediately, with no partial swap completion.
- Handshake: `en`&&`rdy` sampled at edge E. `rdy`=0 from E+1. It stays low for exactly 3+8·L cycles, then returns to 1.
- 8 cycles per message byte. At most one memory write per cycle. S and PT are never written in the same cycle.
- Write enables are high for exactly one cycle per write.

## Configuration
- `PRGA_ASCII_CHECK_EN`
  - **Defined:**
    - Adds output `pt_ok` (1 bit, reset 1, set to 1 on start).
    - In XOR, a computed byte outside 0x20..0x7E is not written: `pt_ok`←0 and the FSM goes straight to DONE.
    - `rdy` timing shortens accordingly.
    - `pt_ok` holds its value until the next start. This supports a downstream key-search stage.
  - **Undefined:** no `pt_ok` port, no check; every byte is written.

## Structure
- Shared package `arc4_pkg` holds:
  - the `prga_state_t` enum,
  - `ARC4_MEM_DEPTH`=256,
  - `ASCII_LO`=8'h20 and `ASCII_HI`=8'h7E,
  - `PRGA_CYC_PER_BYTE`=8.
- No sub-module. This is a single FSM plus datapath registers (i, j, k, L, si, sj).

## Test plan
- S identity (s[x]=x), ct={0} → pt[0]=0, no other PT write, `rdy` low for 3 cycles.
- S identity, ct={1,0x00} → pt={1,0x02}, `rdy` low for 11 cycles.
- S identity, ct={2,0x41,0x42} → pt={2,0x43,0x47}, S afterwards s[2]=3, s[3]=2, all other entries unchanged.
- `rst_n` pulsed low during WR_I of byte 1 → `s_wren`/`pt_wren` fall 0 asynchronously, `rdy`=1, next `en` restarts cleanly from pt[0].
- `en` held high throughout a run → no restart until DONE; second run starts the cycle after `rdy` rises.
- With `PRGA_ASCII_CHECK_EN`: S identity, ct={2,0x00,0x41} → pt[0]=2 written, pt[1] not written, `pt_ok`=0. Without the macro: pt={2,0x02,0x44}.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: PRGA state encoding, memory geometry, printable-ASCII bounds.
package arc4_pkg;

  localparam int unsigned ARC4_MEM_DEPTH    = 256;
  localparam int unsigned PRGA_CYC_PER_BYTE = 8;
  localparam logic [7:0]  ASCII_LO          = 8'h20;
  localparam logic [7:0]  ASCII_HI          = 8'h7E;

  typedef enum logic [3:0] {
    PRGA_IDLE,
    PRGA_RD_LEN,
    PRGA_LD_LEN,
    PRGA_RD_I,
    PRGA_LD_I,
    PRGA_RD_J,
    PRGA_LD_J,
    PRGA_WR_I,
    PRGA_WR_J,
    PRGA_RD_K,
    PRGA_XOR,
    PRGA_DONE
  } prga_state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= ASCII_LO) && (b <= ASCII_HI);
  endfunction

endpackage

// File: rtl/prga.sv
// ARC4 pseudo-random generation: regenerates keystream from S and decrypts CT into PT.
// Optional PRGA_ASCII_CHECK_EN aborts on the first non-printable byte and reports it on pt_ok.
module prga
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
`ifdef PRGA_ASCII_CHECK_EN
  output logic       pt_ok,
`endif
  output logic       pt_wren
);

  prga_state_t state_q, state_d;
  logic [7:0]  i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d, si_q, si_d, sj_q, sj_d;
  logic [7:0]  pt_byte;
`ifdef PRGA_ASCII_CHECK_EN
  logic        pt_ok_q, pt_ok_d;
  assign pt_ok = pt_ok_q;
`endif

  assign pt_byte = s_rddata ^ ct_rddata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PRGA_IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= 8'd0;
      len_q   <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
`ifdef PRGA_ASCII_CHECK_EN
      pt_ok_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
`ifdef PRGA_ASCII_CHECK_EN
      pt_ok_q <= pt_ok_d;
`endif
    end
  end

  // Memory strobes are decoded straight from state so an async reset kills them at once.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
`ifdef PRGA_ASCII_CHECK_EN
    pt_ok_d   = pt_ok_q;
`endif
    rdy       = 1'b0;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = 8'd0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;
    unique case (state_q)
      PRGA_IDLE: begin
        rdy = 1'b1;
        if (en) begin
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = 8'd0;
`ifdef PRGA_ASCII_CHECK_EN
          pt_ok_d = 1'b1;
`endif
          state_d = PRGA_RD_LEN;
        end
      end
      PRGA_RD_LEN: begin
        ct_addr = 8'd0;
        state_d = PRGA_LD_LEN;
      end
      PRGA_LD_LEN: begin
        len_d     = ct_rddata;
        pt_addr   = 8'd0;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
        if (ct_rddata == 8'd0) begin
          state_d = PRGA_DONE;
        end else begin
          k_d     = 8'd1;
          state_d = PRGA_RD_I;
        end
      end
      PRGA_RD_I: begin
        s_addr  = i_q + 8'd1;
        i_d     = i_q + 8'd1;
        state_d = PRGA_LD_I;
      end
      PRGA_LD_I: begin
        si_d    = s_rddata;
        j_d     = j_q + s_rddata;
        state_d = PRGA_RD_J;
      end
      PRGA_RD_J: begin
        s_addr  = j_q;
        state_d = PRGA_LD_J;
      end
      PRGA_LD_J: begin
        sj_d    = s_rddata;
        state_d = PRGA_WR_I;
      end
      PRGA_WR_I: begin
        s_addr   = i_q;
        s_wrdata = sj_q;
        s_wren   = 1'b1;
        state_d  = PRGA_WR_J;
      end
      PRGA_WR_J: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        state_d  = PRGA_RD_K;
      end
      PRGA_RD_K: begin
        // si+sj is invariant under the swap, so the latched copies give the pad address.
        s_addr  = si_q + sj_q;
        ct_addr = k_q;
        state_d = PRGA_XOR;
      end
      PRGA_XOR: begin
`ifdef PRGA_ASCII_CHECK_EN
        if (!is_printable(pt_byte)) begin
          pt_ok_d = 1'b0;
          state_d = PRGA_DONE;
        end else
`endif
        begin
          pt_addr   = k_q;
          pt_wrdata = pt_byte;
          pt_wren   = 1'b1;
          if (k_q == len_q) begin
            state_d = PRGA_DONE;
          end else begin
            k_d     = k_q + 8'd1;
            state_d = PRGA_RD_I;
          end
        end
      end
      PRGA_DONE: state_d = PRGA_IDLE;
      default:   state_d = PRGA_IDLE;
    endcase
  end

endmodule
